// File: rtl/posedge_rate_pkg.sv
// Shared types and constants for the posedge rate-window block.
// No logic, so no latency.
// No flow control here; the buffer depth used by the result FIFO is defined below.
package posedge_rate_pkg;

  // Measurement controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int DEF_CNT_W = 16;  // count / rate word width
  localparam int DEF_WIN_W = 24;  // window length / timer width
  localparam int BUF_DEPTH = 2;   // result buffer entries
  localparam int IDX_W     = 16;  // window index width (optional feature)

endpackage : posedge_rate_pkg

// File: rtl/rate_skid_fifo.sv
// Small shift-register FIFO holding window results; the head is always entry 0.
// Latency: a push is visible at head_dat_o/head_vld_o one cycle later if the FIFO was empty.
// Backpressure: a simultaneous pop frees a slot for a push even when full; a push into a full FIFO without a pop is dropped and flagged on drop_o.
module rate_skid_fifo
  import posedge_rate_pkg::*;
#(
  parameter int DW    = DEF_CNT_W,
  parameter int DEPTH = BUF_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] push_dat_i,
  input  logic          pop_rdy_i,
  output logic [DW-1:0] head_dat_o,
  output logic          head_vld_o,
  output logic          drop_o
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] wr_idx;
  logic          full, pop, push_ok;

  assign full       = (cnt_q == CW'(DEPTH));
  assign head_vld_o = (cnt_q != '0);
  assign head_dat_o = mem_q[0];
  assign pop        = pop_rdy_i && head_vld_o;
  // A pop in the same cycle makes room, so a full FIFO can still accept
  assign push_ok    = push_i && (!full || pop);
  assign drop_o     = push_i && !push_ok;
  // Write slot is the first free entry after any shift caused by the pop
  assign wr_idx     = pop ? (cnt_q - CW'(1)) : cnt_q;

  // Next-state: shift down on pop, then write the new entry behind the survivors
  always_comb begin
    mem_d = mem_q;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i + 1];
      end
    end
    if (push_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_idx == CW'(i)) begin
          mem_d[i] = push_dat_i;
        end
      end
    end
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop);
  end

  // Storage and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule : rate_skid_fifo

// File: rtl/posedge_rate_window.sv
// Turns a free-running edge count into per-window edge totals (delta of cnt_in per window_len cycles).
// Latency: a window closing in cycle N shows on rate_valid in cycle N+1 when the buffer was empty.
// Backpressure: 2-entry valid/ready buffer; results arriving while it is full and not draining are dropped and set sticky overrun.
// Optional: define POSEDGE_RATE_WINDOW_IDX_EN to add rate_idx, the window index carried with each result.
module posedge_rate_window
  import posedge_rate_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int WIN_W = DEF_WIN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] cnt_in,
  output logic [CNT_W-1:0] rate_data,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic             overrun,
  input  logic             overrun_clr,
`ifdef POSEDGE_RATE_WINDOW_IDX_EN
  output logic [IDX_W-1:0] rate_idx,
`endif
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIN_W-1:0] timer_q, timer_d;
  logic [WIN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] base_q, base_d;
  logic [CNT_W-1:0] delta;
  logic             overrun_q, overrun_d;
  logic             arm, win_close, run_tick;
  logic             fifo_drop;

  // Controller state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: dropping en in RUN aborts even on a closing cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = ARM;
      ARM:     state_d = RUN;
      RUN:     if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Controller outputs and datapath strobes
  always_comb begin
    busy      = (state_q == ARM) || (state_q == RUN);
    arm       = (state_q == ARM);
    run_tick  = (state_q == RUN) && en;
    win_close = run_tick && (timer_q == '0);
  end

  // Modular difference gives the right answer across a counter wrap
  assign delta = cnt_in - base_q;

  // Timer, window length and baseline next-state
  always_comb begin
    len_d   = len_q;
    timer_d = timer_q;
    base_d  = base_q;
    if (arm) begin
      // A zero length would never close; treat it as one cycle
      len_d   = (win_len == '0) ? WIN_W'(1) : win_len;
      timer_d = len_d - WIN_W'(1);
      base_d  = cnt_in;
    end else if (win_close) begin
      timer_d = len_q - WIN_W'(1);
      base_d  = cnt_in;
    end else if (run_tick) begin
      timer_d = timer_q - WIN_W'(1);
    end
  end

  // Timer, window length and baseline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q   <= '0;
      timer_q <= '0;
      base_q  <= '0;
    end else begin
      len_q   <= len_d;
      timer_q <= timer_d;
      base_q  <= base_d;
    end
  end

  // Sticky overrun: a fresh drop wins over a clear in the same cycle
  always_comb begin
    overrun_d = overrun_q;
    if (fifo_drop) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  // Overrun flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;

`ifdef POSEDGE_RATE_WINDOW_IDX_EN
  localparam int FW = CNT_W + IDX_W;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [FW-1:0]    fifo_head;

  // Window index restarts on every arm and counts every close, dropped or not
  always_comb begin
    idx_d = idx_q;
    if (arm) begin
      idx_d = '0;
    end else if (win_close) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  // Window index register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  rate_skid_fifo #(
    .DW    (FW),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (win_close),
    .push_dat_i ({idx_q, delta}),
    .pop_rdy_i  (rate_ready),
    .head_dat_o (fifo_head),
    .head_vld_o (rate_valid),
    .drop_o     (fifo_drop)
  );

  assign rate_data = fifo_head[CNT_W-1:0];
  assign rate_idx  = fifo_head[CNT_W +: IDX_W];
`else
  rate_skid_fifo #(
    .DW    (CNT_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (win_close),
    .push_dat_i (delta),
    .pop_rdy_i  (rate_ready),
    .head_dat_o (rate_data),
    .head_vld_o (rate_valid),
    .drop_o     (fifo_drop)
  );
`endif

endmodule : posedge_rate_window

// File: tb/tb_posedge_rate_window.sv
// Self-checking bench for posedge_rate_window: directed scenarios with a result scoreboard.
// Stimulus pushes expected window results; a negedge monitor checks every accepted output.
// Direct checks cover reset, timing, overrun, abort and zero-length windows.
module tb_posedge_rate_window;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [23:0] win_len;
  logic [15:0] cnt_in;
  logic [15:0] rate_data;
  logic        rate_valid;
  logic        rate_ready;
  logic        overrun;
  logic        overrun_clr;
  logic        busy;
`ifdef POSEDGE_RATE_WINDOW_IDX_EN
  logic [15:0] rate_idx;
`endif

  typedef struct {
    logic [15:0] data;
    logic [15:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   mode  = 0;  // 0 hold, 1 +1 every cycle, 2 +1 on 3 of every 10 cycles
  int   ph    = 0;

  always #5 clk = ~clk;

  posedge_rate_window dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .win_len     (win_len),
    .cnt_in      (cnt_in),
    .rate_data   (rate_data),
    .rate_valid  (rate_valid),
    .rate_ready  (rate_ready),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
`ifdef POSEDGE_RATE_WINDOW_IDX_EN
    .rate_idx    (rate_idx),
`endif
    .busy        (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  // Advance n clocks; inputs change 1ns after each rising edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (mode == 1) begin
        cnt_in = cnt_in + 16'd1;
      end else if (mode == 2) begin
        if (ph < 3) cnt_in = cnt_in + 16'd1;
        ph = (ph + 1) % 10;
      end
    end
  endtask

  task automatic expect_res(input logic [15:0] d, input logic [15:0] ix);
    exp_t e;
    e.data = d;
    e.idx  = ix;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: checks each result accepted by the consumer
  always @(negedge clk) begin
    if (rst_n && rate_valid && rate_ready) begin
      exp_t e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got data %0h, expected no result", rate_data);
      end else begin
        e = exp_q.pop_front();
        if (rate_data !== e.data) begin
          fails++;
          $display("FAIL sb_data: got %0h, expected %0h", rate_data, e.data);
        end
`ifdef POSEDGE_RATE_WINDOW_IDX_EN
        tests++;
        if (rate_idx !== e.idx) begin
          fails++;
          $display("FAIL sb_idx: got %0h, expected %0h", rate_idx, e.idx);
        end
`endif
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    en          = 1'b0;
    win_len     = 24'd10;
    cnt_in      = 16'd0;
    rate_ready  = 1'b0;
    overrun_clr = 1'b0;
    #12;
    chk("rst_valid",   32'(rate_valid), 32'd0);
    chk("rst_data",    32'(rate_data),  32'd0);
    chk("rst_overrun", 32'(overrun),    32'd0);
    chk("rst_busy",    32'(busy),       32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(2);

    // Steady rate: 3 edges per 10-cycle window
    win_len = 24'd10; rate_ready = 1'b1; mode = 2; ph = 0;
    for (int k = 0; k < 3; k++) expect_res(16'd3, 16'(k));
    en = 1'b1;
    tick(1);  chk("steady_busy_arm", 32'(busy), 32'd1);
    tick(10); chk("steady_not_yet",  32'(rate_valid), 32'd0);
    tick(1);  chk("steady_first_vld", 32'(rate_valid), 32'd1);
              chk("steady_data", 32'(rate_data), 32'd3);
    tick(1);  chk("steady_popped", 32'(rate_valid), 32'd0);
    tick(9);  chk("steady_second_vld", 32'(rate_valid), 32'd1);
    tick(10);
    en = 1'b0;
    tick(2);  chk("steady_idle_busy", 32'(busy), 32'd0);
    mode = 0;

    // Counter wrap: baseline 0xFFFE, close at 0x0003
    win_len = 24'd5; cnt_in = 16'hFFFD;
    expect_res(16'd5, 16'd0);
    en = 1'b1; mode = 1;
    tick(7);  chk("wrap_data", 32'(rate_data), 32'd5);
    en = 1'b0;
    tick(2);  mode = 0;

    // Backpressure: deltas 1,2,3 with no consumer, third is dropped
    rate_ready = 1'b0; win_len = 24'd10;
    expect_res(16'd1, 16'd0);
    expect_res(16'd2, 16'd1);
    en = 1'b1;
    for (int t = 1; t <= 32; t++) begin
      tick(1);
      if (t == 5)  cnt_in = cnt_in + 16'd1;
      if (t == 15) cnt_in = cnt_in + 16'd2;
      if (t == 25) cnt_in = cnt_in + 16'd3;
      if (t == 31) chk("bp_no_ovr_yet", 32'(overrun), 32'd0);
    end
    chk("bp_overrun", 32'(overrun), 32'd1);
    chk("bp_head",    32'(rate_data), 32'd1);
    en = 1'b0;
    tick(3);  chk("bp_head_stable", 32'(rate_data), 32'd1);
    rate_ready = 1'b1;
    tick(3);  chk("bp_drained", 32'(rate_valid), 32'd0);
              chk("bp_sticky",  32'(overrun),    32'd1);
    overrun_clr = 1'b1;
    tick(1);  overrun_clr = 1'b0;
              chk("bp_clr", 32'(overrun), 32'd0);

    // Full buffer with a pop on the closing cycle accepts the push
    mode = 1; rate_ready = 1'b0; win_len = 24'd4;
    for (int k = 0; k < 3; k++) expect_res(16'd4, 16'(k));
    en = 1'b1;
    tick(13); rate_ready = 1'b1;
    tick(1);  chk("fullpop_no_ovr", 32'(overrun), 32'd0);
              chk("fullpop_vld",    32'(rate_valid), 32'd1);
    en = 1'b0;
    tick(4);  chk("fullpop_drained", 32'(rate_valid), 32'd0);

    // Abort mid-window, then re-arm for a full fresh window
    win_len = 24'd10;
    en = 1'b1;
    tick(6);  chk("abort_busy_run", 32'(busy), 32'd1);
    en = 1'b0;
    tick(1);  chk("abort_busy_off", 32'(busy), 32'd0);
    tick(15); chk("abort_nopush", 32'(rate_valid), 32'd0);
    expect_res(16'd10, 16'd0);
    en = 1'b1;
    tick(1);  chk("rearm_busy", 32'(busy), 32'd1);
    tick(10); chk("rearm_not_yet", 32'(rate_valid), 32'd0);
    tick(1);  chk("rearm_vld",  32'(rate_valid), 32'd1);
              chk("rearm_data", 32'(rate_data), 32'd10);
    en = 1'b0;
    tick(2);

    // Zero window length closes every cycle
    win_len = 24'd0;
    for (int k = 0; k < 4; k++) expect_res(16'd1, 16'(k));
    en = 1'b1;
    tick(2);  chk("len0_not_yet", 32'(rate_valid), 32'd0);
    tick(1);  chk("len0_vld",  32'(rate_valid), 32'd1);
              chk("len0_data", 32'(rate_data), 32'd1);
    tick(3);  en = 1'b0;
    tick(3);  chk("len0_drained", 32'(rate_valid), 32'd0);

    // Asynchronous reset mid-RUN discards the buffered result
    win_len = 24'd3; rate_ready = 1'b0;
    en = 1'b1;
    tick(5);  chk("rstrun_vld", 32'(rate_valid), 32'd1);
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    chk("rstrun_valid",   32'(rate_valid), 32'd0);
    chk("rstrun_data",    32'(rate_data),  32'd0);
    chk("rstrun_busy",    32'(busy),       32'd0);
    chk("rstrun_overrun", 32'(overrun),    32'd0);
    en = 1'b0; mode = 0;
    tick(2);
    rst_n = 1'b1; rate_ready = 1'b1;
    tick(3);  chk("rstrun_stays_empty", 32'(rate_valid), 32'd0);

    // Every expected result must have been seen
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick(1);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_posedge_rate_window
